// File: rtl/pwm_audio_decoder.sv
// pwm_audio_decoder: measures high time and period of each PWM frame on sin; define PWM_DEC_AVG_EN to publish a 4-frame running mean
module pwm_audio_decoder #(
    parameter int CNT_W   = 20,
    parameter int MAX_CNT = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_CNT);
    state_t           r_state, w_next;
    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt, r_h_tmp;
    logic             w_rise, w_fall, w_sat, w_done, w_to, w_pub;
    logic [CNT_W-1:0] w_high, w_period;
    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;
    assign w_sat  = r_cnt == LP_MAX;
    assign w_done = (r_state == LOW) && w_rise;
    assign w_to   = (r_state != IDLE) && (w_next == IDLE);
    // two-stage synchronizer plus one delay stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {r_s1, r_s2, r_s3} <= 3'b000;
        else     {r_s1, r_s2, r_s3} <= {sin, r_s1, r_s2};
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // next state: edges take priority over saturation, saturation drops back to IDLE
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_rise ? HIGH : IDLE;
            HIGH:    w_next = w_fall ? LOW : (w_sat ? IDLE : HIGH);
            LOW:     w_next = w_rise ? HIGH : (w_sat ? IDLE : LOW);
            default: w_next = IDLE;
        endcase
    end
    // frame counter: cleared in IDLE, reloaded to 1 on every rise, saturating at MAX_CNT
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_cnt <= '0;
        else if (w_next == IDLE)  r_cnt <= '0;
        else if (w_rise)          r_cnt <= CNT_W'(1);
        else if (!w_sat)          r_cnt <= r_cnt + CNT_W'(1);
    end
    // high time is captured at the falling edge and published at the closing rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             r_h_tmp <= '0;
        else if (r_state == HIGH && w_fall)  r_h_tmp <= r_cnt;
    end
`ifdef PWM_DEC_AVG_EN
    logic [CNT_W-1:0] r_hh [3];
    logic [CNT_W-1:0] r_ph [3];
    logic [1:0]       r_fill;
    assign w_pub    = w_done && (r_fill == 2'd3);
    assign w_high   = CNT_W'(({2'b00, r_h_tmp} + {2'b00, r_hh[0]} + {2'b00, r_hh[1]} + {2'b00, r_hh[2]}) >> 2);
    assign w_period = CNT_W'(({2'b00, r_cnt} + {2'b00, r_ph[0]} + {2'b00, r_ph[1]} + {2'b00, r_ph[2]}) >> 2);
    // history of the three previous frames; fill count restarts after a timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hh   <= '{default: '0};
            r_ph   <= '{default: '0};
            r_fill <= 2'd0;
        end else if (w_to) begin
            r_fill <= 2'd0;
        end else if (w_done) begin
            r_hh   <= '{r_h_tmp, r_hh[0], r_hh[1]};
            r_ph   <= '{r_cnt, r_ph[0], r_ph[1]};
            r_fill <= (r_fill == 2'd3) ? 2'd3 : r_fill + 2'd1;
        end
    end
`else
    assign w_pub    = w_done;
    assign w_high   = r_h_tmp;
    assign w_period = r_cnt;
`endif
    // published results, one-cycle strobe and sticky timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_cnt   <= '0;
            period_cnt <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid <= w_pub;
            if (w_pub) begin
                high_cnt   <= w_high;
                period_cnt <= w_period;
            end
            timeout <= w_to ? 1'b1 : (w_pub ? 1'b0 : timeout);
        end
    end
endmodule

// File: tb/tb_pwm_audio_decoder.sv
// tb_pwm_audio_decoder: directed frames with a scoreboard of expected measurements
module tb_pwm_audio_decoder;
    localparam int CNT_W   = 20;
    localparam int MAX_CNT = 1000;
    typedef struct {
        int h;
        int p;
        bit gap;
    } exp_t;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sin = 1'b0;
    logic [CNT_W-1:0] high_cnt, period_cnt;
    logic             valid, timeout;
    exp_t             q[$];
    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    int               last_v = 0;
    bit               run_first = 1'b1;

    pwm_audio_decoder #(.CNT_W(CNT_W), .MAX_CNT(MAX_CNT)) dut (
        .clk(clk), .rst(rst), .sin(sin),
        .high_cnt(high_cnt), .period_cnt(period_cnt),
        .valid(valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("valid_unexpected", 32'(valid), 0);
            end else begin
                e = q.pop_front();
                chk("high_cnt", 32'(high_cnt), e.h);
                chk("period_cnt", 32'(period_cnt), e.p);
                chk("timeout_on_valid", 32'(timeout), 0);
                if (e.gap) chk("valid_spacing", cyc - last_v, e.p);
            end
            last_v = cyc;
        end
    endtask

    task automatic frame(input int h, input int p);
        q.push_back('{h, p, !run_first});
        run_first = 1'b0;
        sin = 1'b1;
        repeat (h) tick();
        sin = 1'b0;
        repeat (p - h) tick();
    endtask

    task automatic tail();
        sin = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_high_cnt", 32'(high_cnt), 0);
        chk("rst_period_cnt", 32'(period_cnt), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst = 1'b0;
        repeat (1200) tick();
        chk("idle_no_timeout", 32'(timeout), 0);
        run_first = 1'b1;
        repeat (3) frame(100, 400);
        repeat (2) frame(1, 2);
        repeat (2) frame(399, 400);
        repeat (3) frame(100, 400);
        sin = 1'b1;
        for (int i = 0; i < MAX_CNT + 100 && timeout !== 1'b1; i++) tick();
        chk("timeout_set", 32'(timeout), 1);
        chk("timeout_delay", cyc - last_v, MAX_CNT);
        chk("hold_high_cnt", 32'(high_cnt), 100);
        chk("hold_period_cnt", 32'(period_cnt), 400);
        chk("pending_before_timeout", q.size(), 0);
        sin = 1'b0;
        repeat (300) tick();
        chk("timeout_sticky", 32'(timeout), 1);
        run_first = 1'b1;
        frame(100, 400);
        chk("timeout_until_valid", 32'(timeout), 1);
        frame(100, 400);
        tail();
        chk("timeout_cleared", 32'(timeout), 0);
        chk("pending_after_resume", q.size(), 0);
        repeat (40) tick();
        #1;
        rst = 1'b1;
        sin = 1'b0;
        #1;
        chk("async_rst_high_cnt", 32'(high_cnt), 0);
        chk("async_rst_period_cnt", 32'(period_cnt), 0);
        chk("async_rst_valid", 32'(valid), 0);
        chk("async_rst_timeout", 32'(timeout), 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        run_first = 1'b1;
        frame(100, 400);
        frame(250, 300);
        tail();
        chk("post_rst_high_cnt", 32'(high_cnt), 250);
        chk("post_rst_period_cnt", 32'(period_cnt), 300);
        chk("pending_at_end", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
